// File: rtl/fp_pkg.sv
// fp_pkg: shared FP constants, divider state encoding and IEEE-754 single field helpers.
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] NORM   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
        return x[MAN_W +: EXP_W];
    endfunction

    function automatic logic [MAN_W-1:0] f_frac(input logic [31:0] x);
        return x[MAN_W-1:0];
    endfunction

    // Denormals count as zero: the divider flushes them.
    function automatic logic is_zero(input logic [31:0] x);
        return f_exp(x) == '0;
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return f_exp(x) == '1 && f_frac(x) == '0;
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return f_exp(x) == '1 && f_frac(x) != '0;
    endfunction
endpackage

// File: rtl/fp_divider_if.sv
// fp_divider_if: operand/result handshake bundle of the FP divider.
interface fp_divider_if;
    logic [31:0] Operando_A;
    logic [31:0] Operando_B;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Resultado;
    logic        out_valid;
    logic        out_ready;
    logic        flag_invalid;
    logic        flag_div_zero;
    logic        flag_overflow;
    logic        flag_underflow;

    modport master (
        output Operando_A, Operando_B, in_valid, out_ready,
        input  in_ready, Resultado, out_valid,
               flag_invalid, flag_div_zero, flag_overflow, flag_underflow
    );

    modport slave (
        input  Operando_A, Operando_B, in_valid, out_ready,
        output in_ready, Resultado, out_valid,
               flag_invalid, flag_div_zero, flag_overflow, flag_underflow
    );
endinterface

// File: rtl/fp_div_mant.sv
// fp_div_mant: radix-2 restoring mantissa divider, one quotient bit per clock, 25 bits.
module fp_div_mant (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [24:0] a,
    input  logic [24:0] b,
    output logic [24:0] q,
    output logic        done
);
    logic [24:0] r, d, r_sub;
    logic [4:0]  cnt;
    logic        busy, ge;

    always_comb begin
        ge    = r >= d;
        r_sub = ge ? r - d : r;
    end

    // done stays set until the next start so the FSM may sample it late.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r    <= '0;
            d    <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            r    <= a;
            d    <= b;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            r   <= r_sub << 1;
            q   <= {q[23:0], ge};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd24) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_divider.sv
// fp_divider: multi-cycle IEEE-754 single divider (A / B), truncating, flush-to-zero,
// valid/ready on both sides; specials resolved at accept, normals via fp_div_mant.
module fp_divider
    import fp_pkg::*;
(
    input logic clk,
    input logic rst_n,
    fp_divider_if.slave bus
);
    logic [1:0]          state;
    logic                sign, special, sign_in, inv, sp, ovf, unf, div_done, accept;
    logic signed [9:0]   exp_dif, exp_in, exp_norm;
    logic [31:0]         sp_res;
    logic [24:0]         q;
    logic [MAN_W-1:0]    frac_norm;

    always_comb begin
        accept    = state == IDLE && bus.in_valid;
        sign_in   = f_sign(bus.Operando_A) ^ f_sign(bus.Operando_B);
        inv       = is_nan(bus.Operando_A) | is_nan(bus.Operando_B)
                  | (is_zero(bus.Operando_A) & is_zero(bus.Operando_B))
                  | (is_inf(bus.Operando_A) & is_inf(bus.Operando_B));
        sp        = inv | is_zero(bus.Operando_A) | is_zero(bus.Operando_B)
                  | is_inf(bus.Operando_A) | is_inf(bus.Operando_B);
        sp_res    = inv ? QNAN
                  : (is_zero(bus.Operando_B) | is_inf(bus.Operando_A)) ? (PINF | {sign_in, 31'b0})
                  : {sign_in, 31'b0};
        exp_in    = $signed(10'(f_exp(bus.Operando_A)) - 10'(f_exp(bus.Operando_B)) + 10'(BIAS));
        // Quotient lies in (0.5, 2): q[24] clear means one extra left shift.
        exp_norm  = q[24] ? exp_dif : exp_dif - 10'sd1;
        frac_norm = q[24] ? q[MAN_W:1] : q[MAN_W-1:0];
        ovf       = exp_norm >= 10'sd255;
        unf       = exp_norm <= 10'sd0;
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;

    fp_div_mant u_mant (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && !sp),
        .a     ({2'b01, f_frac(bus.Operando_A)}),
        .b     ({2'b01, f_frac(bus.Operando_B)}),
        .q     (q),
        .done  (div_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            sign               <= 1'b0;
            special            <= 1'b0;
            exp_dif            <= '0;
            bus.Resultado      <= '0;
            bus.flag_invalid   <= 1'b0;
            bus.flag_div_zero  <= 1'b0;
            bus.flag_overflow  <= 1'b0;
            bus.flag_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sign              <= sign_in;
                    exp_dif           <= exp_in;
                    special           <= sp;
                    bus.Resultado     <= sp_res;
                    bus.flag_invalid  <= inv;
                    bus.flag_div_zero <= !inv && is_zero(bus.Operando_B);
                    state             <= sp ? NORM : DIVIDE;
                end
                DIVIDE: if (div_done) state <= NORM;
                NORM: begin
                    state <= DONE;
                    if (!special) begin
                        bus.flag_overflow  <= ovf;
                        bus.flag_underflow <= !ovf && unf;
                        bus.Resultado      <= ovf ? (PINF | {sign, 31'b0})
                                            : unf ? {sign, 31'b0}
                                            : {sign, exp_norm[EXP_W-1:0], frac_norm};
                    end
                end
                DONE: if (bus.out_ready) begin
                    state              <= IDLE;
                    bus.flag_invalid   <= 1'b0;
                    bus.flag_div_zero  <= 1'b0;
                    bus.flag_overflow  <= 1'b0;
                    bus.flag_underflow <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed and random checks of fp_divider against an integer-arithmetic model.
module tb_fp_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    fp_divider_if bus ();

    fp_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags_now();
        return {bus.flag_invalid, bus.flag_div_zero, bus.flag_overflow, bus.flag_underflow};
    endfunction

    // Quotient mantissa as floor(ma * 2^24 / mb), then normalise and truncate.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f, output int lat);
        int     ea, eb, e;
        longint q;
        logic   s, za, zb, ia, ib, na, nb;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = ea == 0;
        zb = eb == 0;
        ia = ea == 255 && a[22:0] == 0;
        ib = eb == 255 && b[22:0] == 0;
        na = ea == 255 && a[22:0] != 0;
        nb = eb == 255 && b[22:0] != 0;
        f   = 4'b0000;
        lat = 1;
        r   = {s, 31'h0};
        if (na || nb || (za && zb) || (ia && ib)) begin
            r = 32'h7FC00000;
            f = 4'b1000;
        end else if (zb) begin
            r = {s, 31'h7F800000};
            f = 4'b0100;
        end else if (ia) begin
            r = {s, 31'h7F800000};
        end else if (!(ib || za)) begin
            lat = 27;
            q = ((longint'(a[22:0]) + 64'h800000) << 24) / (longint'(b[22:0]) + 64'h800000);
            e = ea - eb + 127;
            if (q < 64'h1000000) begin
                e--;
                q = q << 1;
            end
            if (e >= 255) begin
                r = {s, 31'h7F800000};
                f = 4'b0010;
            end else if (e <= 0) begin
                f = 4'b0001;
            end else begin
                r = {s, 8'(e), 23'(q >> 1)};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 9))
            0: x[30:23] = 8'h00;
            1: x[30:23] = 8'hFF;
            2: x[30:0] = 31'h7F800000;
            default: x[30:23] = 8'($urandom_range(1, 254));
        endcase
        return x;
    endfunction

    // Drives one operation, waits (bounded) for the result, then handshakes it out.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] fl,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        bus.Operando_A = a;
        bus.Operando_B = b;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.Operando_A = $urandom;
        bus.Operando_B = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.in_ready) busy_ok = 1'b0;
        end
        res = bus.Resultado;
        fl  = flags_now();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.Operando_A = '0;
        bus.Operando_B = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, flags_now(), bus.Resultado} !== {1'b0, 1'b1, 4'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset: got valid=%b ready=%b flags=%b res=%h expected 0 1 0000 00000000",
                     bus.out_valid, bus.in_ready, flags_now(), bus.Resultado);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va[6] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h80000000, 32'h7F000000, 32'h00800000};
        logic [31:0] vb[6] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000, 32'h40000000};
        logic [31:0] vr[6] = '{32'h40400000, 32'h3EAAAAAA, 32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
        logic [3:0]  vf[6] = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001};
        int          vl[6] = '{27, 27, 1, 1, 27, 27};
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        bit          busy_ok;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], res, fl, lat, busy_ok);
            n_checks += 4;
            if (res !== vr[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] result: got %h expected %h", i, res, vr[i]);
            end
            if (fl !== vf[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] flags: got %b expected %b", i, fl, vf[i]);
            end
            if (lat != vl[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat, vl[i]);
            end
            if (!busy_ok) begin
                n_fail++;
                $display("FAIL directed[%0d] in_ready while busy: got 1 expected 0", i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        bit          busy_ok;
        @(negedge clk);
        bus.Operando_A = 32'h40C00000;
        bus.Operando_B = 32'h40000000;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat != 27) begin
            n_fail++;
            $display("FAIL backpressure latency: got %0d expected 27", lat);
        end
        bus.Operando_A = 32'h3F800000;
        bus.Operando_B = 32'h40400000;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.out_valid, bus.in_ready, flags_now(), bus.Resultado} !== {1'b1, 1'b0, 4'b0, 32'h40400000}) begin
                n_fail++;
                $display("FAIL backpressure hold[%0d]: got valid=%b ready=%b flags=%b res=%h expected 1 0 0000 40400000",
                         i, bus.out_valid, bus.in_ready, flags_now(), bus.Resultado);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure release: got valid=%b ready=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
        run_op(32'h3F800000, 32'h40400000, res, fl, lat, busy_ok);
        n_checks++;
        if ({res, fl} !== {32'h3EAAAAAA, 4'b0}) begin
            n_fail++;
            $display("FAIL backpressure next op: got %h/%b expected 3eaaaaaa/0000", res, fl);
        end
    endtask

    task automatic test_midreset();
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        int          seen;
        bit          busy_ok;
        @(negedge clk);
        bus.Operando_A = 32'h40C00000;
        bus.Operando_B = 32'h40000000;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, flags_now(), bus.Resultado} !== {1'b0, 1'b1, 4'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL midreset outputs: got valid=%b ready=%b flags=%b res=%h expected 0 1 0000 00000000",
                     bus.out_valid, bus.in_ready, flags_now(), bus.Resultado);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midreset spurious result: got %0d valid cycles expected 0", seen);
        end
        run_op(32'h40C00000, 32'h40000000, res, fl, lat, busy_ok);
        n_checks++;
        if ({res, fl, lat} !== {32'h40400000, 4'b0, 32'd27}) begin
            n_fail++;
            $display("FAIL midreset follow-up: got %h/%b/%0d expected 40400000/0000/27", res, fl, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, er;
        logic [3:0]  fl, ef;
        int          lat, el;
        bit          busy_ok;
        for (int i = 0; i < 50; i++) begin
            a = rand_op();
            b = rand_op();
            ref_div(a, b, er, ef, el);
            run_op(a, b, res, fl, lat, busy_ok);
            n_checks += 3;
            if (res !== er) begin
                n_fail++;
                $display("FAIL random %h/%h result: got %h expected %h", a, b, res, er);
            end
            if (fl !== ef) begin
                n_fail++;
                $display("FAIL random %h/%h flags: got %b expected %b", a, b, fl, ef);
            end
            if (lat != el || !busy_ok) begin
                n_fail++;
                $display("FAIL random %h/%h latency: got %0d busy_ok=%b expected %0d busy_ok=1", a, b, lat, busy_ok, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Multi-cycle IEEE-754 single-precision divider (A / B), the division counterpart of the multiplier's exponent-add path.
- Unpacks both operands and subtracts exponents with re-bias.
- Mantissa quotient is produced by a radix-2 restoring iteration (one bit per clock), then normalized and packed.
- Valid/ready on input and output. Sits beside the multiplier in the FP unit.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, fraction field width
- BIAS, 127, exponent bias

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- Operando_A  in  32  dividend (sign, exp, fraction)
- Operando_B  in  32  divisor
- in_valid  in  1  operands valid
- in_ready  out  1  block idle, can accept operands
- Resultado  out  32  quotient
- out_valid  out  1  Resultado and flags valid
- out_ready  in  1  consumer accepts result
- flag_invalid  out  1  NaN input, 0/0, or inf/inf
- flag_div_zero  out  1  finite nonzero / 0
- flag_overflow  out  1  result exponent saturated to inf
- flag_underflow  out  1  result flushed to zero

Behaviour:
- Reset: rst_n low at a clock edge forces state IDLE. Resultado, out_valid and all flags go to 0; in_ready goes to 1 on the following cycle.
  - Applies mid-operation: the current division is discarded and no result is emitted.
- States: IDLE, DIVIDE, NORM, DONE.
- IDLE: in_ready=1. Accept occurs on in_valid&&in_ready at edge T.
  - Latch sign = A[31]^B[31].
  - Latch Exp_dif = A.exp - B.exp + BIAS, held as a 10-bit signed value.
  - Latch mantissas {1,frac}.
  - Special case detected: go to DONE at edge T+1. Otherwise go to DIVIDE.
- Denormal inputs (exp=0, frac!=0) are treated as zero. No denormal outputs are produced (flush-to-zero).
- Special-case priority:
  1. NaN input, 0/0, or inf/inf: Resultado=0x7FC00000, flag_invalid=1.
  2. B=0: ±inf, flag_div_zero=1.
  3. A=inf: ±inf.
  4. B=inf: ±0.
  5. A=0: ±0.
- DIVIDE: 25 iterations, counter 0..24.
  - Remainder R starts at mant_A, divisor D = mant_B, both 25-bit.
  - Each cycle: if R>=D then q_bit=1 and R=R-D, else q_bit=0. Then R=R<<1 and q={q,q_bit}.
  - Result q[24] has weight 2^0. Exit to NORM after the 25th bit.
- NORM, one cycle:
  - q[24]=1: frac=q[23:1].
  - q[24]=0: frac=q[22:0] and Exp_dif -= 1.
  - Rounding is truncation (toward zero).
  - Exp_dif>=255: ±inf (0x7F800000 | sign), flag_overflow.
  - Exp_dif<=0: ±0, flag_underflow.
- DONE: out_valid=1. Resultado and flags are held stable while out_ready=0.
  - On out_valid&&out_ready, return to IDLE. out_valid drops and flags clear next cycle.
- Latency from accept edge T to out_valid high:
  - Special case: after edge T+1.
  - Normal: after edge T+27 (25 DIVIDE cycles + 1 NORM + 1 entry into DONE).
- in_ready=0 in DIVIDE, NORM and DONE. No overlap of operations.
- in_valid while busy is ignored; operands are not captured.
- Operand inputs may change after accept without effect.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, MAN_W, BIAS
  - QNAN=32'h7FC00000, PINF=32'h7F800000
  - state encoding (IDLE, DIVIDE, NORM, DONE)
  - field-extract functions (sign, exp, frac, is_zero, is_inf, is_nan)
- Sub-module fp_div_mant: restoring mantissa divider (start, 25-bit operands, iteration counter, q, done). The FSM, exponent path, specials and packing remain in fp_divider.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> Resultado=0x40400000, no flags; out_valid rises 27 cycles after accept, in_ready low throughout.
- 0x3F800000 / 0x40400000 (1.0/3.0) -> 0x3EAAAAAA (truncated; q[24]=0 path, exponent 125).
- 0x3F800000 / 0x00000000 -> 0x7F800000, flag_div_zero=1; 0x80000000 / 0x00000000 -> 0x7FC00000, flag_invalid=1; both out_valid 1 cycle after accept.
- 0x7F000000 / 0x3E800000 (2^127/0.25) -> 0x7F800000, flag_overflow=1; 0x00800000 / 0x40000000 -> 0x00000000, flag_underflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> Resultado/flags stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle, next operation accepted.
- Assert rst_n=0 for one edge at DIVIDE iteration 12 -> all outputs 0 after that edge, no result emitted; a following 6.0/2.0 produces 0x40400000 normally.
